// File: rtl/tbman_arb.sv
// Two-requester arbiter in front of the tbman native port.
// One transaction in flight at a time: accept (IDLE) -> tbman strobe (ISSUE) -> completion pulse (RESP).
module tbman_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic              tbman_sel,
  output logic              tbman_write,
  output logic [ADDR_W-1:0] tbman_addr,
  output logic [DATA_W-1:0] tbman_wdata,
  input  logic [DATA_W-1:0] tbman_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_ptr;
  logic              r_grant_id;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_gnt_id;
  logic              w_accept;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Winner among valid requesters; only meaningful when at least one is valid.
  always_comb begin
    w_gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : r_rr_ptr;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  always_comb begin
    w_sel_write = w_gnt_id ? req1_write : req0_write;
    w_sel_addr  = w_gnt_id ? req1_addr  : req0_addr;
    w_sel_wdata = w_gnt_id ? req1_wdata : req0_wdata;
  end

  // ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_gnt_id;
          req1_ready  = w_gnt_id;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant_id <= w_gnt_id;
        r_rr_ptr   <= ~w_gnt_id;
      end
    end
  end

  // tbman fields only move on acceptance, so they hold while sel is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= w_sel_write;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == S_ISSUE) begin
      if (r_grant_id) begin
        r_rdata1 <= r_write ? '0 : tbman_rdata;
      end else begin
        r_rdata0 <= r_write ? '0 : tbman_rdata;
      end
    end
  end

  assign tbman_sel   = (r_state == S_ISSUE);
  assign tbman_write = r_write;
  assign tbman_addr  = r_addr;
  assign tbman_wdata = r_wdata;
  assign busy        = (r_state != S_IDLE);
  assign req0_rvalid = (r_state == S_RESP) && !r_grant_id;
  assign req1_rvalid = (r_state == S_RESP) &&  r_grant_id;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

endmodule
